// File: rtl/fir_inverse_if.sv
// Sample stream bundle for fir_inverse: y in with in_valid/in_ready, x out with out_valid/out_ready.
// Latency: none, wires only.
// Backpressure: in_ready and out_ready carry the stall in each direction.
// Ports: in_valid, in_ready, y (W), out_valid, out_ready, xout (W).
// The master modport is the side that drives y and accepts xout; the slave modport is the block.
interface fir_inverse_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] xout;

  modport master (
    output in_valid, y, out_ready,
    input  in_ready, out_valid, xout
  );

  modport slave (
    input  in_valid, y, out_ready,
    output in_ready, out_valid, xout
  );
endinterface

// File: rtl/fir_inverse.sv
// Inverse of the 5-tap FIR (h = 5,4,3,2,1, mod 2^W): recovers x[n] from y[n] with a shift-add multiply by 1/5.
// Latency: out_valid rises N+1 cycles after the accepting edge (N = W/STEP); one sample in flight.
// Backpressure: in_ready only in IDLE with clr low; xout is held in OUT until out_ready.
// Ports: clk, rst (sync, active-high), clr (history clear, IDLE only),
//        io (fir_inverse_if.slave: in_valid/in_ready/y, out_valid/out_ready/xout), busy (state != IDLE).
module fir_inverse #(
  parameter int           W      = 32,
  parameter int           STEP   = 1,
  parameter logic [W-1:0] INV_H0 = 32'hCCCCCCCD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  fir_inverse_if.slave   io,
  output logic           busy
);

  localparam int N  = W / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_MUL,
    S_OUT
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [W-1:0]  ycap;
  logic [W-1:0]  x1, x2, x3, x4;
  logic [W-1:0]  rsh;     // residual, pre-shifted to the weight of the next multiplier bit
  logic [W-1:0]  mreg;    // remaining multiplier bits, lsb = next bit to retire
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  xout_q;

  logic [W-1:0]  r_sub;
  logic [W-1:0]  acc_nxt;
  logic          in_rdy;
  logic          out_vld;
  logic          last_mul;

  // Residual after removing the contribution of the four previous outputs.
  always_comb begin
    r_sub = ycap - (x1 << 2) - ((x2 << 1) + x2) - (x3 << 1) - x4;
  end

  // STEP partial products per cycle; everything wraps at W bits.
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < STEP; j++) begin
      if (mreg[j]) begin
        acc_nxt = acc_nxt + (rsh << j);
      end
    end
  end

  assign last_mul = (cnt == LAST);

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      S_IDLE: begin
        in_rdy = ~clr;
        if (io.in_valid && !clr) begin
          state_nxt = S_SUB;
        end
      end
      S_SUB: begin
        state_nxt = S_MUL;
      end
      S_MUL: begin
        if (last_mul) begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_vld = 1'b1;
        if (io.out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ycap   <= '0;
      x1     <= '0;
      x2     <= '0;
      x3     <= '0;
      x4     <= '0;
      rsh    <= '0;
      mreg   <= '0;
      acc    <= '0;
      cnt    <= '0;
      xout_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr) begin
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
            x4 <= '0;
          end else if (io.in_valid) begin
            ycap <= io.y;
          end
        end
        S_SUB: begin
          rsh  <= r_sub;
          mreg <= INV_H0;
          acc  <= '0;
          cnt  <= '0;
        end
        S_MUL: begin
          acc  <= acc_nxt;
          rsh  <= rsh << STEP;
          mreg <= mreg >> STEP;
          cnt  <= cnt + 1'b1;
          // History moves only here, so an output stall cannot shift it twice.
          if (last_mul) begin
            xout_q <= acc_nxt;
            x1     <= acc_nxt;
            x2     <= x1;
            x3     <= x2;
            x4     <= x3;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io.in_ready  = in_rdy;
  assign io.out_valid = out_vld;
  assign io.xout      = xout_q;
  assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_fir_inverse.sv
module tb_fir_inverse;

  localparam int          N1  = 32;
  localparam int          N4  = 8;
  localparam logic [31:0] INV = 32'hCCCCCCCD;

  logic clk;
  logic rst;
  logic clr;
  logic busy;
  logic clr4;
  logic busy4;
  int   cyc;
  int   checks;
  int   failures;

  fir_inverse_if #(.W(32)) ifc ();
  fir_inverse_if #(.W(32)) if4 ();

  fir_inverse #(.W(32), .STEP(1), .INV_H0(INV)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .io   (ifc),
    .busy (busy)
  );

  fir_inverse #(.W(32), .STEP(4), .INV_H0(INV)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr4),
    .io   (if4),
    .busy (busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h time=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference FIR and model state.
  function automatic logic [31:0] fir(input logic [31:0] x, input logic [31:0] h0,
                                      input logic [31:0] h1, input logic [31:0] h2,
                                      input logic [31:0] h3);
    return 32'd5 * x + 32'd4 * h0 + 32'd3 * h1 + 32'd2 * h2 + h3;
  endfunction

  logic [31:0] mh[4];        // model history of recovered x, [0] newest
  logic [31:0] mq[$];        // expected outputs in flight
  int          acc_k;        // edge number at which the in-flight sample was accepted

  // Per-cycle compare against the model; updates take effect for the coming edge.
  always @(negedge clk) begin
    logic        exp_idle;
    logic        exp_ov;
    logic [31:0] e;
    if (cyc > 0) begin
      exp_idle = (mq.size() == 0);
      exp_ov   = !exp_idle && (cyc >= acc_k + N1 + 1);
      chk("in_ready", 32'(ifc.in_ready), 32'(exp_idle && !clr));
      chk("busy", 32'(busy), 32'(!exp_idle));
      chk("out_valid", 32'(ifc.out_valid), 32'(exp_ov));
      if (ifc.out_valid && exp_ov) chk("xout", ifc.xout, mq[0]);
      if (rst) begin
        mq.delete();
        for (int i = 0; i < 4; i++) mh[i] = '0;
      end else if (exp_idle) begin
        if (clr) begin
          for (int i = 0; i < 4; i++) mh[i] = '0;
        end else if (ifc.in_valid) begin
          e = (ifc.y - 32'd4 * mh[0] - 32'd3 * mh[1] - 32'd2 * mh[2] - mh[3]) * INV;
          mq.push_back(e);
          acc_k = cyc + 1;
          mh[3] = mh[2]; mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = e;
        end
      end else if (exp_ov && ifc.out_ready) begin
        void'(mq.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Send one y, check latency and the literal expected x; optional output stall.
  task automatic send(input logic [31:0] yv, input logic [31:0] ex, input int stall, input string nm);
    int          n;
    logic [31:0] got;
    n = 0;
    while (!ifc.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    ifc.out_ready = (stall == 0);
    ifc.in_valid  = 1'b1;
    ifc.y         = yv;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.y        = '0;
    n = 0;
    while (!ifc.out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(N1 + 1));
    got = ifc.xout;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_xout", ifc.xout, ex);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    chk(nm, got, ex);
  endtask

  initial begin
    logic [31:0] xs;
    logic [31:0] yv;
    logic [31:0] h[4];
    int          n;

    cyc = 0; checks = 0; failures = 0; acc_k = 0;
    for (int i = 0; i < 4; i++) mh[i] = '0;
    rst = 1'b1; clr = 1'b0; clr4 = 1'b0;
    ifc.in_valid = 1'b0; ifc.y = '0; ifc.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.y = '0; if4.out_ready = 1'b1;
    do_reset();

    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_xout", ifc.xout, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // Impulse
    send(32'd5, 32'd1, 0, "imp0");
    send(32'd4, 32'd0, 0, "imp1");
    send(32'd3, 32'd0, 0, "imp2");
    send(32'd2, 32'd0, 0, "imp3");
    send(32'd1, 32'd0, 0, "imp4");
    send(32'd0, 32'd0, 0, "imp5");

    // Step
    do_reset();
    send(32'd5,  32'd1, 0, "step0");
    send(32'd9,  32'd1, 0, "step1");
    send(32'd12, 32'd1, 0, "step2");
    send(32'd14, 32'd1, 0, "step3");
    send(32'd15, 32'd1, 0, "step4");
    send(32'd15, 32'd1, 0, "step5");
    send(32'd15, 32'd1, 0, "step6");

    // Wrap-around
    do_reset();
    send(32'hFFFFFFFB, 32'hFFFFFFFF, 0, "wrap0");
    send(32'hFFFFFFFC, 32'h00000000, 0, "wrap1");

    // Backpressure: 10-cycle stall, then y=0 with all-ones history gives -2
    do_reset();
    send(32'd5,  32'd1, 0, "bp0");
    send(32'd9,  32'd1, 0, "bp1");
    send(32'd12, 32'd1, 0, "bp2");
    send(32'd14, 32'd1, 0, "bp3");
    send(32'd15, 32'd1, 10, "bp_stall");
    send(32'd0,  32'hFFFFFFFE, 0, "bp_after");

    // Reset during multiply
    do_reset();
    send(32'd5, 32'd1, 0, "pre_abort");
    ifc.in_valid = 1'b1; ifc.y = 32'd123;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("abort_out_valid", 32'(ifc.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send(32'd5, 32'd1, 0, "post_abort");

    // clr beats in_valid
    do_reset();
    send(32'd5, 32'd1, 0, "clr_pre");
    clr = 1'b1; ifc.in_valid = 1'b1; ifc.y = 32'd77;
    #1 chk("clr_in_ready", 32'(ifc.in_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; ifc.in_valid = 1'b0;
    chk("clr_not_accepted", 32'(busy), 32'd0);
    send(32'd5, 32'd1, 0, "clr_post");

    // Random sequence through the reference FIR; history now {1,0,0,0}
    h[0] = 32'd1; h[1] = '0; h[2] = '0; h[3] = '0;
    for (int k = 0; k < 1000; k++) begin
      xs = $urandom;
      yv = fir(xs, h[0], h[1], h[2], h[3]);
      send(yv, xs, 0, "rand");
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = xs;
    end

    // STEP=4 instance: latency N+1 and exact recovery
    for (int i = 0; i < 4; i++) h[i] = '0;
    for (int k = 0; k < 20; k++) begin
      xs = (k == 0) ? 32'd1 : $urandom;
      yv = fir(xs, h[0], h[1], h[2], h[3]);
      n = 0;
      while (!if4.in_ready && n < 100) begin
        @(posedge clk); #1; n++;
      end
      if4.in_valid = 1'b1; if4.y = yv;
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
      chk("s4_busy", 32'(busy4), 32'd1);
      n = 0;
      while (!if4.out_valid && n < 100) begin
        @(posedge clk); #1; n++;
      end
      chk("s4_lat", 32'(n), 32'(N4 + 1));
      chk("s4_xout", if4.xout, xs);
      @(posedge clk); #1;
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = xs;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
